// File: rtl/huff_pkg.sv
// Shared Huffman front-end types: default entry geometry, symbol count and packed entry.
// The packed entry type is also used by the downstream sort network.
package huff_pkg;

    localparam int DSIZE  = 18;
    localparam int OFFSET = 8;
    localparam int NSYM   = 16;

    typedef struct packed {
        logic [DSIZE-OFFSET-1:0] count;
        logic [OFFSET-1:0]       tag;
    } entry_t;

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/freq_counter.sv
// One CW-bit symbol-frequency counter with synchronous clear and increment.
// Define FREQ_HIST_SAT_EN to saturate at all-ones instead of wrapping.
module freq_counter #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
`ifdef FREQ_HIST_SAT_EN
            if (count_q != {CW{1'b1}}) begin
                count_d = count_q + CW'(1);
            end
`else
            count_d = count_q + CW'(1);
`endif
        end
    end

    // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/freq_hist_x16.sv
// 16-symbol frame histogram: counts accepted symbols, then holds {count, tag} entries
// for the sorter until consumed. FREQ_HIST_SAT_EN selects saturating counters.
module freq_hist_x16 #(
    parameter int DSIZE  = huff_pkg::DSIZE,
    parameter int OFFSET = huff_pkg::OFFSET
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [3:0]            sym_data,
    input  logic                  sym_last,
    output logic                  entry_valid,
    input  logic                  entry_ready,
    output logic [16*DSIZE-1:0]   entries
);

    localparam int CW = DSIZE - OFFSET;

    huff_pkg::state_e state_q;
    huff_pkg::state_e state_d;
    logic             accept;
    logic             clr_all;

    // Handshake outputs are pure functions of state, so entry_ready never reaches sym_ready.
    always_comb begin
        state_d     = state_q;
        sym_ready   = 1'b0;
        entry_valid = 1'b0;
        case (state_q)
            huff_pkg::ST_COUNT: begin
                sym_ready = 1'b1;
                if (sym_valid && sym_last) begin
                    state_d = huff_pkg::ST_HOLD;
                end
            end
            huff_pkg::ST_HOLD: begin
                entry_valid = 1'b1;
                if (entry_ready) begin
                    state_d = huff_pkg::ST_COUNT;
                end
            end
            default: state_d = huff_pkg::ST_COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= huff_pkg::ST_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept  = sym_valid && sym_ready;
    assign clr_all = entry_valid && entry_ready;

    for (genvar i = 0; i < huff_pkg::NSYM; i++) begin : g_bin
        localparam logic [3:0]        SYM = 4'(i);
        localparam logic [OFFSET-1:0] TAG = OFFSET'(i);
        logic [CW-1:0] count;

        freq_counter #(
            .CW (CW)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (accept && (sym_data == SYM)),
            .clr_i   (clr_all),
            .count_o (count)
        );

        assign entries[i*DSIZE +: DSIZE] = {count, TAG};
    end

endmodule

// File: tb/tb_freq_hist_x16.sv
// Directed self-checking bench for freq_hist_x16; expectations follow FREQ_HIST_SAT_EN.
module tb_freq_hist_x16;

    localparam int DSIZE  = 18;
    localparam int OFFSET = 8;
    localparam int CW     = DSIZE - OFFSET;

    logic                 clk;
    logic                 rst_n;
    logic                 sym_valid;
    logic                 sym_ready;
    logic [3:0]           sym_data;
    logic                 sym_last;
    logic                 entry_valid;
    logic                 entry_ready;
    logic [16*DSIZE-1:0]  entries;

    int n_cmp;
    int n_err;

    logic [CW-1:0] exp_cnt [16];

    freq_hist_x16 #(
        .DSIZE  (DSIZE),
        .OFFSET (OFFSET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_data    (sym_data),
        .sym_last    (sym_last),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entries     (entries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16*DSIZE-1:0] build_exp();
        logic [16*DSIZE-1:0] r;
        logic [OFFSET-1:0]   tag;
        for (int i = 0; i < 16; i++) begin
            tag = OFFSET'(i);
            r[i*DSIZE +: DSIZE] = {exp_cnt[i], tag};
        end
        return r;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_cnt[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] sym, input logic last);
        sym_valid = 1'b1;
        sym_data  = sym;
        sym_last  = last;
        tick();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic cmp_state(input string name, input logic exp_ev, input logic exp_sr);
        n_cmp++;
        if (entry_valid !== exp_ev || sym_ready !== exp_sr) begin
            n_err++;
            $display("FAIL %s: entry_valid/sym_ready got %b/%b want %b/%b",
                     name, entry_valid, sym_ready, exp_ev, exp_sr);
        end
    endtask

    task automatic cmp_entries(input string name);
        logic [16*DSIZE-1:0] e;
        e = build_exp();
        n_cmp++;
        if (entries !== e) begin
            n_err++;
            $display("FAIL %s: entries got %h want %h", name, entries, e);
        end
    endtask

    task automatic release_hold();
        entry_ready = 1'b1;
        tick();
        entry_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        clear_exp();
        cmp_state("reset_asserted", 1'b0, 1'b1);
        cmp_entries("reset_entries");
        rst_n = 1'b1;
        tick();
        cmp_state("reset_released", 1'b0, 1'b1);
        cmp_entries("reset_released_entries");
    endtask

    task automatic test_basic_frame();
        clear_exp();
        send_beat(4'd3, 1'b0);
        cmp_state("basic_mid", 1'b0, 1'b1);
        send_beat(4'd3, 1'b0);
        sym_valid = 1'b1; sym_data = 4'd5; sym_last = 1'b1;
        cmp_state("basic_before_last_edge", 1'b0, 1'b1);
        tick();
        sym_valid = 1'b0; sym_last = 1'b0;
        exp_cnt[3] = CW'(2);
        exp_cnt[5] = CW'(1);
        cmp_state("basic_hold", 1'b1, 1'b0);
        cmp_entries("basic_entries");
    endtask

    task automatic test_hold_stall();
        logic [16*DSIZE-1:0] snap;
        snap = entries;
        sym_valid = 1'b1; sym_data = 4'd9; sym_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            cmp_state("stall_state", 1'b1, 1'b0);
            n_cmp++;
            if (entries !== snap) begin
                n_err++;
                $display("FAIL stall_entries cycle %0d: got %h want %h", c, entries, snap);
            end
        end
        sym_valid = 1'b0; sym_last = 1'b0;
        cmp_entries("stall_entries_model");
        release_hold();
        clear_exp();
        cmp_state("stall_released", 1'b0, 1'b1);
        cmp_entries("stall_cleared");
    endtask

    task automatic test_ready_in_count();
        clear_exp();
        entry_ready = 1'b1;
        cmp_state("ready_in_count", 1'b0, 1'b1);
        send_beat(4'd0, 1'b0);
        send_beat(4'd0, 1'b0);
        entry_ready = 1'b0;
        exp_cnt[0] = CW'(2);
        cmp_state("ready_in_count_after", 1'b0, 1'b1);
        cmp_entries("ready_in_count_entries");
        send_beat(4'd1, 1'b1);
        exp_cnt[1] = CW'(1);
        cmp_entries("ready_in_count_frame");
        release_hold();
    endtask

    task automatic test_count_limit();
        clear_exp();
        for (int k = 0; k < 1024; k++) begin
            send_beat(4'd7, (k == 1023));
        end
`ifdef FREQ_HIST_SAT_EN
        exp_cnt[7] = {CW{1'b1}};
`else
        exp_cnt[7] = '0;
`endif
        cmp_state("limit_hold", 1'b1, 1'b0);
        cmp_entries("limit_entries");
        release_hold();
    endtask

    task automatic test_single_beat();
        clear_exp();
        sym_valid = 1'b1; sym_data = 4'd15; sym_last = 1'b1;
        cmp_state("single_before", 1'b0, 1'b1);
        tick();
        sym_valid = 1'b0; sym_last = 1'b0;
        exp_cnt[15] = CW'(1);
        cmp_state("single_latency", 1'b1, 1'b0);
        cmp_entries("single_entries");
        release_hold();
    endtask

    task automatic test_mid_frame_reset();
        clear_exp();
        send_beat(4'd2, 1'b0);
        send_beat(4'd4, 1'b0);
        send_beat(4'd4, 1'b0);
        send_beat(4'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        cmp_state("midreset_asserted", 1'b0, 1'b1);
        cmp_entries("midreset_cleared");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            cmp_state("midreset_no_pulse", 1'b0, 1'b1);
        end
        send_beat(4'd4, 1'b0);
        send_beat(4'd8, 1'b1);
        exp_cnt[4] = CW'(1);
        exp_cnt[8] = CW'(1);
        cmp_state("midreset_next_hold", 1'b1, 1'b0);
        cmp_entries("midreset_next_entries");
        release_hold();
    endtask

    task automatic test_back_to_back();
        entry_ready = 1'b1;
        clear_exp();
        send_beat(4'd1, 1'b0);
        send_beat(4'd1, 1'b0);
        send_beat(4'd2, 1'b1);
        exp_cnt[1] = CW'(2);
        exp_cnt[2] = CW'(1);
        cmp_state("b2b_a_hold", 1'b1, 1'b0);
        cmp_entries("b2b_a_entries");
        sym_valid = 1'b1; sym_data = 4'd10; sym_last = 1'b0;
        tick();
        sym_valid = 1'b0;
        clear_exp();
        cmp_state("b2b_one_hold_cycle", 1'b0, 1'b1);
        cmp_entries("b2b_cleared");
        send_beat(4'd4, 1'b1);
        exp_cnt[4] = CW'(1);
        cmp_state("b2b_b_hold", 1'b1, 1'b0);
        cmp_entries("b2b_b_entries");
        tick();
        entry_ready = 1'b0;
        clear_exp();
        cmp_state("b2b_end", 1'b0, 1'b1);
        cmp_entries("b2b_end_entries");
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        sym_valid   = 1'b0;
        sym_data    = '0;
        sym_last    = 1'b0;
        entry_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_hold_stall();
        test_ready_in_count();
        test_count_limit();
        test_single_beat();
        test_mid_frame_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
